// File: rtl/mat_vec_loader.sv
// mat_vec_loader: assembles a serial stream into a matrix/vector operand set with framing checks; MAT_VEC_LOADER_VEC_REUSE_EN adds reuse_vec
module mat_vec_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int MAT_ROW = 4,
  parameter int MAT_COL = 4
) (
  input  logic clk,
  input  logic rst_n,
`ifdef MAT_VEC_LOADER_VEC_REUSE_EN
  input  logic reuse_vec,
`endif
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_last,
  output logic [MAT_ROW-1:0][MAT_COL-1:0][DATA_WIDTH-1:0] out_mat,
  output logic [MAT_COL-1:0][DATA_WIDTH-1:0] out_vec,
  output logic out_valid,
  input  logic out_ready,
  output logic err_frame
);
  localparam int N = MAT_ROW * MAT_COL;
  localparam int IW = $clog2(N + 1);
  typedef enum logic [1:0] {LOAD_MAT, LOAD_VEC, PRESENT} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic beat, reuse, final_beat, mat_done, err_nx;
  assign in_ready = state != PRESENT;
  assign out_valid = state == PRESENT;
  assign beat = in_valid && in_ready;
`ifdef MAT_VEC_LOADER_VEC_REUSE_EN
  logic reuse_q;
  assign reuse = idx == '0 ? reuse_vec : reuse_q;
  // hold the reuse request taken on the first matrix beat for the rest of the frame
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) reuse_q <= 1'b0;
    else if (beat && state == LOAD_MAT && idx == '0) reuse_q <= reuse_vec;
`else
  assign reuse = 1'b0;
`endif
  assign final_beat = state == LOAD_VEC ? idx == IW'(MAT_COL - 1) : idx == IW'(N - 1) && reuse;
  assign mat_done = state == LOAD_MAT && idx == IW'(N - 1) && !reuse;
  // state, index and error pulse registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= LOAD_MAT;
      idx <= '0;
      err_frame <= 1'b0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      err_frame <= err_nx;
    end
  // next state: in_last must coincide exactly with the final beat, otherwise the frame is dropped
  always_comb begin
    state_nx = state;
    idx_nx = idx;
    err_nx = 1'b0;
    if (state == PRESENT) begin
      if (out_ready) begin
        state_nx = LOAD_MAT;
        idx_nx = '0;
      end
    end else if (beat) begin
      if (in_last != final_beat) begin
        err_nx = 1'b1;
        state_nx = LOAD_MAT;
        idx_nx = '0;
      end else if (final_beat) begin
        state_nx = PRESENT;
        idx_nx = '0;
      end else if (mat_done) begin
        state_nx = LOAD_VEC;
        idx_nx = '0;
      end else idx_nx = idx + 1'b1;
    end
  end
  // operand storage: each accepted beat lands in the slot selected by phase and index
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_mat <= '0;
      out_vec <= '0;
    end else if (beat) begin
      for (int r = 0; r < MAT_ROW; r++)
        for (int c = 0; c < MAT_COL; c++)
          if (state == LOAD_MAT && idx == IW'(r * MAT_COL + c)) out_mat[r][c] <= in_data;
      for (int c = 0; c < MAT_COL; c++)
        if (state == LOAD_VEC && idx == IW'(c)) out_vec[c] <= in_data;
    end
endmodule
